// File: rtl/spikecnt_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spikecnt_scheduler
// Purpose  : Windowed spike-count capture. Every WIN cycles of RUN, all
//            channel counts are latched into shadow registers, the counters
//            are cleared, and the latched values are presented one channel
//            at a time over a valid/ready handshake in ascending order.
// Revision : 1.0  initial release
// ============================================================================
module spikecnt_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int CHW = 2,
  parameter int WIN = 8
) (
  input  logic              slow_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NCH*CW-1:0] cnt_in,
  output logic [NCH-1:0]    clear_out,
  output logic [CW-1:0]     out_data,
  output logic [CHW-1:0]    out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              window_done,
  output logic              overrun
);

  localparam int             WCW        = $clog2(WIN);
  localparam logic [WCW-1:0] c_win_last = WCW'(WIN - 1);
  localparam logic [CHW-1:0] c_ptr_last = CHW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [WCW-1:0] r_win_cnt;
  logic [WCW-1:0] w_win_cnt_nxt;
  logic [CW-1:0]  r_shadow [NCH];
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] w_pend_kept;
  logic [CHW-1:0] r_ptr;
  logic           w_capture;
  logic           w_xfer;

  assign out_valid = |r_pend;
  assign out_ch    = r_ptr;
  assign out_data  = r_shadow[r_ptr];
  assign w_xfer    = out_valid & out_ready;

  // Pending mask as it would stand after this edge's transfer (if any);
  // a capture finding anything left here has discarded undrained results.
  assign w_pend_kept = w_xfer ? (r_pend & ~(NCH'(1) << r_ptr)) : r_pend;

  // Next-state, window counter and capture decision
  always_comb begin
    w_state_nxt   = r_state;
    w_win_cnt_nxt = '0;
    w_capture     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = RUN;
      end
      RUN: begin
        if (!enable) begin
          w_state_nxt = (|r_pend) ? FLUSH : IDLE;
        end else if (r_win_cnt == c_win_last) begin
          w_capture = 1'b1;
        end else begin
          w_win_cnt_nxt = r_win_cnt + 1'b1;
        end
      end
      FLUSH: begin
        if (enable)       w_state_nxt = RUN;
        else if (!(|r_pend)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and window counter registers
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_win_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_win_cnt <= w_win_cnt_nxt;
    end
  end

  // Capture-or-drain bookkeeping: capture takes precedence over a transfer
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
      r_ptr  <= '0;
    end else if (w_capture) begin
      r_pend <= '1;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_pend <= w_pend_kept;
      r_ptr  <= (r_ptr == c_ptr_last) ? '0 : r_ptr + 1'b1;
    end
  end

  // Shadow copies of the live counts, taken only at capture
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) r_shadow[i] <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < NCH; i++) r_shadow[i] <= cnt_in[i*CW +: CW];
    end
  end

  // One-cycle capture pulses and the sticky overrun flag
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      clear_out   <= '0;
      window_done <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      clear_out   <= w_capture ? '1 : '0;
      window_done <= w_capture;
      if (w_capture && (|w_pend_kept)) overrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spikecnt_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spikecnt_scheduler
// Purpose  : Scoreboard bench for spikecnt_scheduler (NCH=4, CW=32, WIN=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_spikecnt_scheduler;

  logic         slow_clk = 1'b0;
  logic         reset    = 1'b1;
  logic         enable   = 1'b0;
  logic [127:0] cnt_in   = '0;
  logic [3:0]   clear_out;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         window_done;
  logic         overrun;

  int n_pass  = 0;
  int n_total = 0;
  logic [33:0] exp_q [$];

  spikecnt_scheduler #(.NCH(4), .CW(32), .CHW(2), .WIN(8)) dut (
    .slow_clk    (slow_clk),
    .reset       (reset),
    .enable      (enable),
    .cnt_in      (cnt_in),
    .clear_out   (clear_out),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .window_done (window_done),
    .overrun     (overrun)
  );

  // Free-running clock
  always #5 slow_clk = ~slow_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic set_cnt(input logic [31:0] c0, c1, c2, c3);
    cnt_in = {c3, c2, c1, c0};
  endtask

  task automatic push4(input logic [31:0] c0, c1, c2, c3);
    exp_q.push_back({2'd0, c0});
    exp_q.push_back({2'd1, c1});
    exp_q.push_back({2'd2, c2});
    exp_q.push_back({2'd3, c3});
  endtask

  // Waits (bounded) for window_done and checks how many edges it took
  task automatic wait_capture(input string name, input int exp_n);
    int n;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (window_done) begin
        n = i;
        break;
      end
    end
    chk(name, 64'(n), 64'(exp_n));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},   64'(out_valid),   64'd0);
    chk({tag, "_data"},    64'(out_data),    64'd0);
    chk({tag, "_ch"},      64'(out_ch),      64'd0);
    chk({tag, "_clear"},   64'(clear_out),   64'd0);
    chk({tag, "_wdone"},   64'(window_done), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun),     64'd0);
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard
  always @(negedge slow_clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL xfer_unexpected: got ch %0d data %0d, expected nothing", out_ch, out_data);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("xfer_ch",   64'(out_ch),   64'(e[33:32]));
        chk("xfer_data", 64'(out_data), 64'(e[31:0]));
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    chk_all_zero("rst");
    reset = 1'b0;
    tick();

    // Basic window: capture 8 cycles into RUN, then 4 back-to-back transfers
    out_ready = 1'b1;
    set_cnt(10, 20, 30, 40);
    push4(10, 20, 30, 40);
    enable = 1'b1;
    wait_capture("s1_latency", 9);
    chk("s1_clear",   64'(clear_out), 64'hF);
    chk("s1_overrun", 64'(overrun),   64'd0);
    tick();
    chk("s1_wdone_pulse", 64'(window_done), 64'd0);
    chk("s1_clear_pulse", 64'(clear_out),   64'd0);
    tick(); tick(); tick();
    chk("s1_drained", 64'(out_valid), 64'd0);
    enable = 1'b0;
    tick(); tick();

    // Backpressure: head result held for 3 cycles
    out_ready = 1'b0;
    set_cnt(11, 22, 33, 44);
    enable = 1'b1;
    wait_capture("s2_latency", 9);
    for (int i = 0; i < 3; i++) begin
      chk("s2_hold_valid", 64'(out_valid), 64'd1);
      chk("s2_hold_ch",    64'(out_ch),    64'd0);
      chk("s2_hold_data",  64'(out_data),  64'd11);
      tick();
    end
    chk("s2_hold_data_end", 64'(out_data), 64'd11);
    push4(11, 22, 33, 44);
    out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    chk("s2_drained", 64'(out_valid), 64'd0);
    enable = 1'b0;
    tick(); tick();

    // Overrun: nothing drained across a full window
    out_ready = 1'b0;
    set_cnt(1, 2, 3, 4);
    enable = 1'b1;
    wait_capture("s3_latency1", 9);
    chk("s3_overrun_before", 64'(overrun),  64'd0);
    chk("s3_first_data",     64'(out_data), 64'd1);
    set_cnt(50, 60, 70, 80);
    wait_capture("s3_latency2", 8);
    chk("s3_overrun", 64'(overrun),  64'd1);
    chk("s3_ch",      64'(out_ch),   64'd0);
    chk("s3_data",    64'(out_data), 64'd50);
    push4(50, 60, 70, 80);
    out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    chk("s3_drained", 64'(out_valid), 64'd0);
    chk("s3_sticky",  64'(overrun),   64'd1);
    enable = 1'b0;
    tick(); tick();

    // Flush: enable drops with two results still pending
    out_ready = 1'b0;
    set_cnt(6, 7, 8, 9);
    enable = 1'b1;
    wait_capture("s4_latency", 9);
    push4(6, 7, 8, 9);
    out_ready = 1'b1;
    tick(); tick();
    chk("s4_two_left_ch", 64'(out_ch), 64'd2);
    enable = 1'b0;
    tick(); tick();
    chk("s4_flushed", 64'(out_valid), 64'd0);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (clear_out != 4'd0 || window_done) pulses++;
      end
      chk("s4_no_pulses", 64'(pulses), 64'd0);
    end
    chk("s4_sticky", 64'(overrun), 64'd1);

    // Reset mid-drain, then a fresh full window
    out_ready = 1'b0;
    set_cnt(10, 20, 30, 40);
    enable = 1'b1;
    wait_capture("s5_latency1", 9);
    exp_q.push_back({2'd0, 32'd10});
    exp_q.push_back({2'd1, 32'd20});
    out_ready = 1'b1;
    tick(); tick();
    chk("s5_mid_ch", 64'(out_ch), 64'd2);
    reset = 1'b1;
    #1;
    chk_all_zero("s5_rst");
    tick();
    push4(10, 20, 30, 40);
    reset = 1'b0;
    wait_capture("s5_latency2", 9);
    tick(); tick(); tick(); tick();
    chk("s5_drained", 64'(out_valid), 64'd0);
    enable = 1'b0;
    tick(); tick();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spikecnt_scheduler.md
SPIKECNT_SCHEDULER -- requirements
Module: spikecnt_scheduler

Interface
REQ-001 Parameter NCH, default 4: number of spike-counter channels served.
REQ-002 Parameter CW, default 32: count width per channel.
REQ-003 Parameter CHW, default 2: channel-index width; SHALL equal ceil(log2(NCH)), minimum 1.
REQ-004 Parameter WIN, default 8: counting-window length in slow_clk cycles, minimum 2.
REQ-005 slow_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  run the window timer while high.
REQ-008 cnt_in  input  NCH*CW  live channel counts; channel i at bits [i*CW +: CW].
REQ-009 clear_out  output  NCH  per-channel clear pulse to the spike counters.
REQ-010 out_data  output  CW  latched count of the channel being presented.
REQ-011 out_ch  output  CHW  index of the channel being presented.
REQ-012 out_valid  output  1  out_data/out_ch hold a pending result.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 window_done  output  1  one-cycle pulse marking a window capture.
REQ-015 overrun  output  1  sticky flag: a capture overwrote undrained results.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and FLUSH, plus a window counter win_cnt (0..WIN-1), shadow registers shadow[NCH], a pending mask pend[NCH] and a pointer ptr.
REQ-017 IDLE: win_cnt held at 0; enable=1 -> RUN.
REQ-018 RUN: win_cnt increments each cycle and wraps WIN-1 -> 0; enable=0 -> FLUSH if pend!=0, else IDLE; win_cnt cleared to 0 on leaving RUN.
REQ-019 FLUSH: win_cnt held at 0 and draining continues; enable=1 -> RUN, with win_cnt starting at 0; pend==0 with enable=0 -> IDLE.
REQ-020 Capture: on the edge where state=RUN and win_cnt=WIN-1 (and enable=1), the block SHALL load shadow[i]<=cnt_in channel i for all i, set pend to all ones and ptr to 0, and register clear_out=all ones and window_done=1 for exactly the following cycle.
REQ-021 clear_out and window_done SHALL be 0 in every cycle not directly following a capture edge.
REQ-022 out_valid SHALL equal (pend!=0); out_ch=ptr; out_data=shadow[ptr].
REQ-023 A transfer occurs on an edge where out_valid=1 and out_ready=1. It SHALL clear pend[ptr] and advance ptr by one (0..NCH-1 ascending, no wrap needed).
REQ-024 While out_valid=1 and out_ready=0, out_data and out_ch SHALL hold stable, except when overwritten by a capture.
REQ-025 Channels SHALL be presented strictly in ascending order 0..NCH-1, exactly once per capture.
REQ-026 A transfer and a capture on the same edge: the capture wins (pend all ones, ptr 0). overrun SHALL be set if pend with the transferred bit removed was nonzero.
REQ-027 A capture with pend!=0 and no transfer on that edge SHALL set overrun.
REQ-028 Once set, overrun SHALL stay set until reset.
REQ-029 Count values pass through unmodified at full CW width; there is no arithmetic on the data.

Reset
REQ-030 Asserting reset at any time, including mid-drain, SHALL immediately force: state=IDLE, win_cnt=0, ptr=0, pend=0, shadow=0, clear_out=0, window_done=0, out_valid=0, out_data=0, out_ch=0, overrun=0.
REQ-031 After reset deasserts, no capture SHALL occur until WIN full RUN cycles have elapsed.

Verification
REQ-032 NCH=4, WIN=8; enable=1, out_ready=1, cnt_in={40,30,20,10} (ch3..ch0) -> capture 8 cycles after entering RUN; clear_out=4'hF and window_done=1 for 1 cycle; out_ch 0,1,2,3 carrying 10,20,30,40 on 4 consecutive cycles; overrun=0.
REQ-033 Backpressure: out_ready=0 for 3 cycles after capture -> out_valid=1, out_ch=0, out_data=10 held stable; then ready=1 -> remaining channels drain in order.
REQ-034 Overrun: out_ready=0 for the full window -> second capture reloads shadow, out_ch returns to 0, overrun=1 and stays 1.
REQ-035 Drop enable with 2 results pending -> state FLUSH; both drain; then IDLE; no further clear_out pulses.
REQ-036 Assert reset mid-drain (ptr=2) -> all outputs 0 next sample; re-enable -> first capture exactly WIN cycles later.
